// File: rtl/calc1_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | calc1_pkg: command/response codes, widths and driver state type    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package calc1_pkg;

  localparam int CMD_W  = 4;
  localparam int DATA_W = 32;
  localparam int RESP_W = 2;

  localparam logic [CMD_W-1:0] CMD_NONE = 4'd0;
  localparam logic [CMD_W-1:0] CMD_ADD  = 4'd1;
  localparam logic [CMD_W-1:0] CMD_SUB  = 4'd2;
  localparam logic [CMD_W-1:0] CMD_SHL  = 4'd5;
  localparam logic [CMD_W-1:0] CMD_SHR  = 4'd6;

  localparam logic [RESP_W-1:0] RESP_NONE = 2'd0;
  localparam logic [RESP_W-1:0] RESP_OK   = 2'd1;
  localparam logic [RESP_W-1:0] RESP_ERR  = 2'd2;
  localparam logic [RESP_W-1:0] RESP_TMO  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_DATA = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } drv_state_t;

endpackage
`default_nettype wire

// File: rtl/calc1_req_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | calc1_req_fifo: synchronous request FIFO with registered flags     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module calc1_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 68
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_count_full = c_cnt_w'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [c_cnt_w-1:0] w_count_nxt;
  logic               r_full;
  logic               r_empty;
  logic               w_wr;
  logic               w_rd;

  // A simultaneous pop frees the slot, so a full FIFO can still take a write.
  assign w_wr = i_push && (!r_full || i_pop);
  assign w_rd = i_pop && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_rd})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_count_full);
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule
`default_nettype wire

// File: rtl/calc1_port_driver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | calc1_port_driver: queues operations, drives one calc1 port, returns |
// | the response with a timeout guard.                       rev 1.0   |
// +--------------------------------------------------------------------+
module calc1_port_driver
  import calc1_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CMD_W-1:0]  req_cmd,
  input  logic [DATA_W-1:0] req_op1,
  input  logic [DATA_W-1:0] req_op2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RESP_W-1:0] rsp_resp,
  output logic [DATA_W-1:0] rsp_data,
  output logic [CMD_W-1:0]  calc_cmd,
  output logic [DATA_W-1:0] calc_data,
  input  logic [RESP_W-1:0] calc_resp,
  input  logic [DATA_W-1:0] calc_result,
  output logic              spurious_err
);

  localparam int c_fifo_w = CMD_W + 2 * DATA_W;
  localparam int c_cnt_w  = $clog2(TIMEOUT);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

  drv_state_t          r_state;
  drv_state_t          w_state_nxt;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_push;
  logic                w_pop;
  logic [c_fifo_w-1:0] w_fifo_wdata;
  logic [c_fifo_w-1:0] w_fifo_rdata;
  logic [CMD_W-1:0]    w_head_cmd;
  logic [DATA_W-1:0]   w_head_op1;
  logic [DATA_W-1:0]   w_head_op2;
  logic [CMD_W-1:0]    r_op_cmd;
  logic [DATA_W-1:0]   r_op1;
  logic [DATA_W-1:0]   r_op2;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_cnt_w-1:0]  w_cnt_nxt;
  logic [CMD_W-1:0]    r_calc_cmd;
  logic [CMD_W-1:0]    w_calc_cmd;
  logic [DATA_W-1:0]   r_calc_data;
  logic [DATA_W-1:0]   w_calc_data;
  logic                w_latch;
  logic [RESP_W-1:0]   w_lat_resp;
  logic [DATA_W-1:0]   w_lat_data;
  logic                r_rsp_valid;
  logic [RESP_W-1:0]   r_rsp_resp;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_spurious;

  assign w_push       = req_valid && !w_fifo_full;
  assign w_pop        = (r_state == ST_IDLE) && !w_fifo_empty;
  assign w_fifo_wdata = {req_cmd, req_op1, req_op2};
  assign {w_head_cmd, w_head_op1, w_head_op2} = w_fifo_rdata;

  calc1_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (c_fifo_w)
  ) u_req_fifo (
    .clk     (c_clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_fifo_wdata),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Port values are decoded from the current state and registered, so the
  // calc1 port lags the state by one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_calc_cmd  = CMD_NONE;
    w_calc_data = '0;
    w_latch     = 1'b0;
    w_lat_resp  = RESP_NONE;
    w_lat_data  = '0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) w_state_nxt = ST_CMD;
      end
      ST_CMD: begin
        w_calc_cmd  = r_op_cmd;
        w_calc_data = r_op1;
        w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        w_calc_data = r_op2;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (calc_resp != RESP_NONE) begin
          w_latch     = 1'b1;
          w_lat_resp  = calc_resp;
          w_lat_data  = calc_result;
          w_state_nxt = ST_DONE;
        end else if (r_cnt == c_cnt_last) begin
          w_latch     = 1'b1;
          w_lat_resp  = RESP_TMO;
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_op_cmd    <= CMD_NONE;
      r_op1       <= '0;
      r_op2       <= '0;
      r_calc_cmd  <= CMD_NONE;
      r_calc_data <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_resp  <= RESP_NONE;
      r_rsp_data  <= '0;
      r_spurious  <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_calc_cmd  <= w_calc_cmd;
      r_calc_data <= w_calc_data;
      r_rsp_valid <= (w_state_nxt == ST_DONE);
      if (w_pop) begin
        r_op_cmd <= w_head_cmd;
        r_op1    <= w_head_op1;
        r_op2    <= w_head_op2;
      end
      if (w_latch) begin
        r_rsp_resp <= w_lat_resp;
        r_rsp_data <= w_lat_data;
      end
      if ((calc_resp != RESP_NONE) && (r_state != ST_WAIT)) r_spurious <= 1'b1;
    end
  end

  assign req_ready    = !w_fifo_full;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_resp     = r_rsp_resp;
  assign rsp_data     = r_rsp_data;
  assign calc_cmd     = r_calc_cmd;
  assign calc_data    = r_calc_data;
  assign spurious_err = r_spurious;

endmodule
`default_nettype wire

// File: tb/tb_calc1_port_driver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_calc1_port_driver: directed bench with a behavioural calc1 port |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_calc1_port_driver;
  import calc1_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 16;
  localparam int MODEL_LAT  = 1;

  logic              c_clk = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [CMD_W-1:0]  req_cmd = '0;
  logic [DATA_W-1:0] req_op1 = '0;
  logic [DATA_W-1:0] req_op2 = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [RESP_W-1:0] rsp_resp;
  logic [DATA_W-1:0] rsp_data;
  logic [CMD_W-1:0]  calc_cmd;
  logic [DATA_W-1:0] calc_data;
  logic [RESP_W-1:0] calc_resp;
  logic [DATA_W-1:0] calc_result;
  logic              spurious_err;

  logic              model_en = 1'b1;
  logic [RESP_W-1:0] inject_resp = '0;
  int                n_checks = 0;
  int                n_pass = 0;
  int                n_fail = 0;

  always #5 c_clk = ~c_clk;

  calc1_port_driver #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_cmd      (req_cmd),
    .req_op1      (req_op1),
    .req_op2      (req_op2),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_resp     (rsp_resp),
    .rsp_data     (rsp_data),
    .calc_cmd     (calc_cmd),
    .calc_data    (calc_data),
    .calc_resp    (calc_resp),
    .calc_result  (calc_result),
    .spurious_err (spurious_err)
  );

  function automatic logic [RESP_W+DATA_W-1:0] calc1_eval(
    input logic [CMD_W-1:0] cmd, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    case (cmd)
      CMD_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        calc1_eval = s[DATA_W] ? {RESP_ERR, 32'd0} : {RESP_OK, s[DATA_W-1:0]};
      end
      CMD_SUB: calc1_eval = (a < b) ? {RESP_ERR, 32'd0} : {RESP_OK, a - b};
      CMD_SHL: calc1_eval = {RESP_OK, a << b[4:0]};
      CMD_SHR: calc1_eval = {RESP_OK, a >> b[4:0]};
      default: calc1_eval = {RESP_ERR, 32'd0};
    endcase
  endfunction

  // calc1 port model: captures cmd/op1 then op2, answers MODEL_LAT cycles later.
  int                m_stage;
  int                m_dly;
  logic [CMD_W-1:0]  m_cmd;
  logic [DATA_W-1:0] m_op1;
  logic [DATA_W-1:0] m_op2;

  initial begin
    calc_resp = RESP_NONE;
    calc_result = '0;
    m_stage = 0;
    m_dly = 0;
    m_cmd = '0;
    m_op1 = '0;
    m_op2 = '0;
    forever begin
      @(negedge c_clk);
      calc_resp = RESP_NONE;
      calc_result = '0;
      if (!reset) begin
        m_stage = 0;
      end else begin
        case (m_stage)
          0: if (calc_cmd != CMD_NONE) begin
            m_cmd = calc_cmd;
            m_op1 = calc_data;
            m_stage = 1;
          end
          1: begin
            m_op2 = calc_data;
            m_dly = MODEL_LAT;
            m_stage = 2;
          end
          default: begin
            if (m_dly > 1) begin
              m_dly--;
            end else begin
              if (model_en) {calc_resp, calc_result} = calc1_eval(m_cmd, m_op1, m_op2);
              m_stage = 0;
            end
          end
        endcase
      end
      if (inject_resp != RESP_NONE) calc_resp = inject_resp;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic acc;
    acc = req_valid && req_ready;
    @(posedge c_clk);
    #1;
    if (acc) req_valid = 1'b0;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic push(input logic [CMD_W-1:0] cmd, input logic [31:0] a, input logic [31:0] b);
    int guard;
    req_cmd = cmd;
    req_op1 = a;
    req_op2 = b;
    req_valid = 1'b1;
    guard = 0;
    while (req_valid && guard < 200) begin
      step();
      guard++;
    end
    chk("push_accepted", {31'd0, req_valid}, 32'd0);
  endtask

  task automatic wait_rsp(input string tag, output int n);
    n = 0;
    while (!rsp_valid && n < 200) begin
      step();
      n++;
    end
    chk(tag, {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic take();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [CMD_W-1:0] cmd, input logic [31:0] a,
                        input logic [31:0] b, input logic [RESP_W-1:0] exp_resp);
    int n;
    push(cmd, a, b);
    wait_rsp({tag, "_valid"}, n);
    chk({tag, "_resp"}, {30'd0, rsp_resp}, {30'd0, exp_resp});
    take();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_resp"}, {30'd0, rsp_resp}, 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    chk({tag, "_calc_cmd"}, {28'd0, calc_cmd}, 32'd0);
    chk({tag, "_calc_data"}, calc_data, 32'd0);
    chk({tag, "_spurious"}, {31'd0, spurious_err}, 32'd0);
  endtask

  logic [31:0] q_exp [6];

  initial begin
    int n;
    int bad;

    #12;
    chk_reset_values("rst");
    @(posedge c_clk);
    #1;
    reset = 1'b1;
    steps(2);

    // Single ADD: cycle-exact port sequence and response latency
    push(CMD_ADD, 32'h1, 32'h1FFF_FFFF);
    step();
    chk("add_cmd_n1", {28'd0, calc_cmd}, 32'd0);
    step();
    chk("add_cmd_n2", {28'd0, calc_cmd}, 32'd1);
    chk("add_data_n2", calc_data, 32'h1);
    step();
    chk("add_cmd_n3", {28'd0, calc_cmd}, 32'd0);
    chk("add_data_n3", calc_data, 32'h1FFF_FFFF);
    step();
    chk("add_valid_n4", {31'd0, rsp_valid}, 32'd0);
    step();
    chk("add_valid_n5", {31'd0, rsp_valid}, 32'd1);
    chk("add_resp", {30'd0, rsp_resp}, 32'd1);
    chk("add_data", rsp_data, 32'h2000_0000);
    steps(3);
    chk("add_hold_valid", {31'd0, rsp_valid}, 32'd1);
    chk("add_hold_data", rsp_data, 32'h2000_0000);
    take();
    chk("add_taken", {31'd0, rsp_valid}, 32'd0);

    // Error responses
    run_op("add_ovf", CMD_ADD, 32'hFFFF_FFFF, 32'h1, RESP_ERR);
    run_op("sub_udf", CMD_SUB, 32'h1, 32'hF, RESP_ERR);
    run_op("cmd3", 4'd3, 32'h5, 32'h6, RESP_ERR);

    // Timeout with a second op queued behind it
    model_en = 1'b0;
    push(CMD_ADD, 32'h4, 32'h5);
    push(CMD_SHL, 32'h1, 32'h1);
    wait_rsp("tmo_valid", n);
    chk("tmo_latency", n, 32'd18);
    chk("tmo_resp", {30'd0, rsp_resp}, 32'd3);
    chk("tmo_data", rsp_data, 32'd0);
    model_en = 1'b1;
    take();
    wait_rsp("after_tmo_valid", n);
    chk("after_tmo_resp", {30'd0, rsp_resp}, 32'd1);
    chk("after_tmo_data", rsp_data, 32'h2);
    take();

    // Six ops with the consumer stalled: one in flight, four queued, one held
    q_exp[0] = 32'h2;
    q_exp[1] = 32'h30;
    q_exp[2] = 32'h10;
    q_exp[3] = 32'd12;
    q_exp[4] = 32'd7;
    q_exp[5] = 32'h8000_0000;
    push(CMD_SHL, 32'h1, 32'h1);
    push(CMD_SHL, 32'h3, 32'h4);
    push(CMD_SHR, 32'h80, 32'h3);
    push(CMD_ADD, 32'd5, 32'd7);
    chk("q_ready_after4", {31'd0, req_ready}, 32'd1);
    push(CMD_SUB, 32'd10, 32'd3);
    chk("q_ready_after5", {31'd0, req_ready}, 32'd0);
    req_cmd = CMD_SHL;
    req_op1 = 32'h1;
    req_op2 = 32'd31;
    req_valid = 1'b1;
    steps(20);
    chk("q_ready_stalled", {31'd0, req_ready}, 32'd0);
    chk("q_first_valid", {31'd0, rsp_valid}, 32'd1);
    chk("q_first_hold", rsp_data, 32'h2);
    for (int i = 0; i < 6; i++) begin
      wait_rsp($sformatf("q%0d_valid", i), n);
      chk($sformatf("q%0d_resp", i), {30'd0, rsp_resp}, 32'd1);
      chk($sformatf("q%0d_data", i), rsp_data, q_exp[i]);
      take();
    end
    steps(4);
    chk("q_drained_valid", {31'd0, rsp_valid}, 32'd0);
    chk("q_drained_ready", {31'd0, req_ready}, 32'd1);

    // Response pulse outside WAIT
    inject_resp = RESP_OK;
    step();
    inject_resp = RESP_NONE;
    chk("spur_set", {31'd0, spurious_err}, 32'd1);
    steps(5);
    chk("spur_sticky", {31'd0, spurious_err}, 32'd1);
    chk("spur_no_rsp", {31'd0, rsp_valid}, 32'd0);

    // Reset while waiting on calc1 with two ops queued
    model_en = 1'b0;
    push(CMD_ADD, 32'd1, 32'd1);
    push(CMD_ADD, 32'd2, 32'd2);
    push(CMD_ADD, 32'd3, 32'd3);
    steps(3);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_values("midrst");
    steps(2);
    reset = 1'b1;
    model_en = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (rsp_valid || (calc_cmd != CMD_NONE)) bad++;
    end
    chk("midrst_quiet", bad, 32'd0);
    push(CMD_ADD, 32'd2, 32'd3);
    wait_rsp("post_rst_valid", n);
    chk("post_rst_resp", {30'd0, rsp_resp}, 32'd1);
    chk("post_rst_data", rsp_data, 32'd5);
    take();

    if (n_fail != 0) $display("%0d comparisons did not match", n_fail);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/calc1_port_driver.md
# calc1_port_driver

Upstream request sequencer for one port of the `calc1` calculator. It accepts whole operations (command plus two operands) over a valid/ready interface and buffers them in a small FIFO. It serialises each operation onto the calc1 two-cycle port protocol: the command with operand 1, then a null command with operand 2. It then captures the one-cycle calc1 response and returns it to the consumer over a second valid/ready interface, with a timeout guard. One instance sits in front of each calc1 port (req1..req4).

## Interface
- `FIFO_DEPTH`, 4: request FIFO entries; power of two, ≥2.
- `TIMEOUT`, 16: cycles spent in WAIT without a calc1 response before a timeout result is returned; ≥4.
- `c_clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; asserting it clears all state immediately.
- `req_valid`  in  1  operation offered.
- `req_ready`  out  1  FIFO not full.
- `req_cmd`  in  [0:3]  calc1 command; passed through unchecked.
- `req_op1`, `req_op2`  in  [0:31]  operands.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_resp`  out  [0:1]  1 = success, 2 = overflow/underflow/invalid (from calc1), 3 = timeout (generated locally).
- `rsp_data`  out  [0:31]  calc1 result; 0 when `rsp_resp` = 3.
- `calc_cmd`  out  [0:3]  to calc1 `reqN_cmd_in`.
- `calc_data`  out  [0:31]  to calc1 `reqN_data_in`.
- `calc_resp`  in  [0:1]  from calc1 `out_respN`.
- `calc_result`  in  [0:31]  from calc1 `out_dataN`.
- `spurious_err`  out  1  sticky; set when `calc_resp` ≠ 0 outside WAIT.

## Operation
- FIFO push on `req_valid && req_ready`. FIFO pop only in IDLE when the FIFO is non-empty.
- A push and a pop in the same cycle are both honoured, including when the FIFO is full.
- States:
  - IDLE: `calc_cmd` = 0, `calc_data` = 0. If the FIFO is non-empty, pop into the op register and go to CMD.
  - CMD: drive `calc_cmd` = cmd, `calc_data` = op1. Go to DATA.
  - DATA: drive `calc_cmd` = 0, `calc_data` = op2. Clear the timeout counter. Go to WAIT.
  - WAIT: drive `calc_cmd` = 0, `calc_data` = 0.
    - On `calc_resp` ≠ 0, latch `calc_resp`/`calc_result` and go to DONE.
    - Otherwise increment the counter. When the counter reaches TIMEOUT−1, latch resp = 3, data = 0, and go to DONE.
  - DONE: `rsp_valid` = 1. On `rsp_ready`, go to IDLE.
- Exactly one operation is outstanding at calc1; no pipelining across operations.
- `rsp_resp`/`rsp_data` hold stable while `rsp_valid` is high and not accepted.
- A response arriving in the same cycle as the timeout terminal count takes priority over the timeout.
- `spurious_err` is cleared only by reset.

## Timing
- Reset values: `req_ready` = 1, `rsp_valid` = 0, `rsp_resp` = 0, `rsp_data` = 0, `calc_cmd` = 0, `calc_data` = 0, `spurious_err` = 0. FIFO empty, state IDLE.
- All outputs are registered.
- Pushed at edge N into an empty FIFO with IDLE: command appears on `calc_cmd` after edge N+2, op2 after edge N+3.
- Response pulse `calc_resp` ≠ 0 in cycle K → `rsp_valid` high after edge K+1.
- Back-to-back throughput is limited by calc1 latency plus 4 cycles (IDLE, CMD, DATA, DONE).
- Reset asserted mid-operation: the in-flight op and all FIFO contents are discarded. `calc_cmd` returns to 0 asynchronously; calc1 is reset in parallel by the system.
- `req_ready` deasserts in the cycle after the FIFO fills. It does not depend combinationally on `rsp_ready`.

## Structure
- Shared package `calc1_pkg`:
  - command codes: ADD = 1, SUB = 2, SHL = 5, SHR = 6;
  - response codes: NONE = 0, OK = 1, ERR = 2, TMO = 3;
  - widths: CMD_W = 4, DATA_W = 32, RESP_W = 2;
  - state enum.
- One sub-module, `calc1_req_fifo`: a synchronous FIFO, 68 bits wide, with full/empty flags and the same reset.

## Test plan
- ADD 0x1 + 0x1FFFFFFF with a calc1 model attached → `rsp_resp` = 1, `rsp_data` = 0x20000000; `calc_cmd` sequence 1, 0 on consecutive cycles.
- ADD 0xFFFFFFFF + 0x1 → `rsp_resp` = 2. SUB 0x1 − 0xF → `rsp_resp` = 2. Command 3 → `rsp_resp` = 2.
- `calc_resp` tied to 0 → `rsp_resp` = 3, `rsp_data` = 0, exactly TIMEOUT cycles after DATA. The next queued op then proceeds normally.
- Push 6 ops back-to-back with `rsp_ready` = 0 → 1 in flight plus 4 queued. `req_ready` drops after the 5th push. Release `rsp_ready` → all 6 results return in order (SHL 0x1 → 0x2, …).
- `calc_resp` = 1 pulsed while in IDLE → `spurious_err` = 1 and stays 1; no `rsp_valid`.
- Reset asserted during WAIT with 2 ops queued → all outputs at reset values immediately. After release, no result is produced until a new push.
